// File: rtl/l3fwd_meas_ctrl.sv
// Measurement sequencer for the L3 forwarding latency counter: paces counter windows,
// strobes per-window reads and folds the window results into host-readable aggregates.
module l3fwd_meas_ctrl #(
    parameter int C_CNTR_WIDTH = 64,
    parameter int C_NWIN_WIDTH = 16
) (
    input  logic                    user_clk,
    input  logic                    user_resetn,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic [C_CNTR_WIDTH-1:0] cfg_window,
    input  logic [C_NWIN_WIDTH-1:0] cfg_num_win,
    input  logic                    cfg_en,
    input  logic                    cfg_mode,
    output logic [C_CNTR_WIDTH-1:0] l3fwd_max,
    output logic                    l3fwd_en,
    output logic                    l3fwd_mode,
    output logic                    l3fwd_rst,
    output logic                    l3fwd_read,
    input  logic [C_CNTR_WIDTH-1:0] win_max_i,
    input  logic [C_CNTR_WIDTH-1:0] win_min_i,
    input  logic [C_CNTR_WIDTH-1:0] win_sum_i,
    input  logic [C_CNTR_WIDTH-1:0] win_pkts_i,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [C_NWIN_WIDTH-1:0] win_cnt,
    output logic [C_CNTR_WIDTH-1:0] agg_max,
    output logic [C_CNTR_WIDTH-1:0] agg_min,
    output logic [C_CNTR_WIDTH-1:0] agg_sum,
    output logic [C_CNTR_WIDTH-1:0] agg_pkts,
    output logic                    agg_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [C_CNTR_WIDTH-1:0] CNTR_ZERO = {C_CNTR_WIDTH{1'b0}};
    localparam logic [C_CNTR_WIDTH-1:0] CNTR_ONES = {C_CNTR_WIDTH{1'b1}};
    localparam logic [C_CNTR_WIDTH-1:0] W_MIN     = C_CNTR_WIDTH'(3);
    localparam logic [C_NWIN_WIDTH-1:0] NWIN_ZERO = {C_NWIN_WIDTH{1'b0}};
    localparam logic [C_NWIN_WIDTH-1:0] NWIN_ONE  = C_NWIN_WIDTH'(1);

    // Saturating add; the MSB of the result flags that saturation occurred.
    function automatic logic [C_CNTR_WIDTH:0] sat_add(
        input logic [C_CNTR_WIDTH-1:0] a,
        input logic [C_CNTR_WIDTH-1:0] b
    );
        logic [C_CNTR_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[C_CNTR_WIDTH]) begin
            sat_add = {1'b1, CNTR_ONES};
        end else begin
            sat_add = s;
        end
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [C_CNTR_WIDTH-1:0] tmr_r;
    logic [C_CNTR_WIDTH-1:0] max_r;
    logic [C_NWIN_WIDTH-1:0] num_win_r;
    logic                    en_r, mode_r, rst_r, read_r;
    logic                    busy_r, done_r, aborted_r;
    logic [C_NWIN_WIDTH-1:0] win_cnt_r;
    logic [C_CNTR_WIDTH-1:0] agg_max_r, agg_min_r, agg_sum_r, agg_pkts_r;
    logic                    agg_ovf_r;

    logic                    start_s, abort_s, trigger_s, sample_s, last_s;
    logic [C_NWIN_WIDTH-1:0] win_cnt_inc_s;
    logic [C_CNTR_WIDTH:0]   sum_add_s, pkts_add_s;

    // Next-state logic plus the per-cycle run events.
    always_comb begin
        state_nxt_s   = state_r;
        start_s       = 1'b0;
        abort_s       = 1'b0;
        trigger_s     = (state_r == RUN) && (tmr_r == max_r);
        sample_s      = (state_r == RUN) && read_r;
        win_cnt_inc_s = (&win_cnt_r) ? win_cnt_r : (win_cnt_r + NWIN_ONE);
        last_s        = sample_s && (num_win_r != NWIN_ZERO) && (win_cnt_inc_s == num_win_r);
        case (state_r)
            IDLE, DONE: begin
                if (cfg_start) begin
                    state_nxt_s = RUN;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                if (cfg_abort) begin
                    state_nxt_s = DONE;
                    abort_s     = 1'b1;
                end else if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Saturating adders for the two running sums.
    always_comb begin
        sum_add_s  = sat_add(agg_sum_r, win_sum_i);
        pkts_add_s = sat_add(agg_pkts_r, win_pkts_i);
    end

    // State register.
    always_ff @(posedge user_clk or negedge user_resetn) begin
        if (!user_resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter control, window timer and run status.
    always_ff @(posedge user_clk or negedge user_resetn) begin
        if (!user_resetn) begin
            tmr_r     <= CNTR_ZERO;
            max_r     <= CNTR_ZERO;
            num_win_r <= NWIN_ZERO;
            en_r      <= 1'b0;
            mode_r    <= 1'b0;
            rst_r     <= 1'b1;
            read_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else if (start_s) begin
            // Window length is clamped so the counter always has room to settle.
            tmr_r     <= CNTR_ZERO;
            max_r     <= (cfg_window < W_MIN) ? W_MIN : cfg_window;
            num_win_r <= cfg_num_win;
            en_r      <= cfg_en;
            mode_r    <= cfg_mode;
            rst_r     <= 1'b0;
            read_r    <= 1'b0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else if (state_r == RUN) begin
            if (state_nxt_s == RUN) begin
                tmr_r  <= trigger_s ? CNTR_ZERO : (tmr_r + C_CNTR_WIDTH'(1));
                read_r <= trigger_s;
            end else begin
                tmr_r     <= CNTR_ZERO;
                read_r    <= 1'b0;
                rst_r     <= 1'b1;
                en_r      <= 1'b0;
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                aborted_r <= abort_s;
            end
        end else begin
            rst_r  <= 1'b1;
            en_r   <= 1'b0;
            read_r <= 1'b0;
        end
    end

    // Aggregation of the per-window results, one update per sample cycle.
    always_ff @(posedge user_clk or negedge user_resetn) begin
        if (!user_resetn) begin
            win_cnt_r  <= NWIN_ZERO;
            agg_max_r  <= CNTR_ZERO;
            agg_min_r  <= CNTR_ONES;
            agg_sum_r  <= CNTR_ZERO;
            agg_pkts_r <= CNTR_ZERO;
            agg_ovf_r  <= 1'b0;
        end else if (start_s) begin
            win_cnt_r  <= NWIN_ZERO;
            agg_max_r  <= CNTR_ZERO;
            agg_min_r  <= CNTR_ONES;
            agg_sum_r  <= CNTR_ZERO;
            agg_pkts_r <= CNTR_ZERO;
            agg_ovf_r  <= 1'b0;
        end else if (sample_s) begin
            win_cnt_r <= win_cnt_inc_s;
            if (win_max_i > agg_max_r) begin
                agg_max_r <= win_max_i;
            end else begin
                agg_max_r <= agg_max_r;
            end
            // Empty windows report a meaningless minimum and must not pull it down.
            if ((win_pkts_i != CNTR_ZERO) && (win_min_i < agg_min_r)) begin
                agg_min_r <= win_min_i;
            end else begin
                agg_min_r <= agg_min_r;
            end
            agg_sum_r  <= sum_add_s[C_CNTR_WIDTH-1:0];
            agg_pkts_r <= pkts_add_s[C_CNTR_WIDTH-1:0];
            agg_ovf_r  <= agg_ovf_r | sum_add_s[C_CNTR_WIDTH] | pkts_add_s[C_CNTR_WIDTH];
        end else begin
            win_cnt_r <= win_cnt_r;
        end
    end

    assign l3fwd_max  = max_r;
    assign l3fwd_en   = en_r;
    assign l3fwd_mode = mode_r;
    assign l3fwd_rst  = rst_r;
    assign l3fwd_read = read_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign aborted    = aborted_r;
    assign win_cnt    = win_cnt_r;
    assign agg_max    = agg_max_r;
    assign agg_min    = agg_min_r;
    assign agg_sum    = agg_sum_r;
    assign agg_pkts   = agg_pkts_r;
    assign agg_ovf    = agg_ovf_r;

endmodule

// File: tb/tb_l3fwd_meas_ctrl.sv
// Self-checking bench for l3fwd_meas_ctrl: directed runs from the test plan plus
// randomized runs, all checked against a window-level reference model.
module tb_l3fwd_meas_ctrl;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        user_clk = 1'b0;
    logic        user_resetn = 1'b0;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0, cfg_en = 1'b0, cfg_mode = 1'b0;
    logic [63:0] cfg_window = 64'd0;
    logic [15:0] cfg_num_win = 16'd0;
    logic [63:0] l3fwd_max;
    logic        l3fwd_en, l3fwd_mode, l3fwd_rst, l3fwd_read;
    logic [63:0] win_max_i = 64'd0, win_min_i = 64'd0, win_sum_i = 64'd0, win_pkts_i = 64'd0;
    logic        busy, done, aborted, agg_ovf;
    logic [15:0] win_cnt;
    logic [63:0] agg_max, agg_min, agg_sum, agg_pkts;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] t_max[4], t_min[4], t_sum[4], t_pkts[4];

    l3fwd_meas_ctrl #(.C_CNTR_WIDTH(64), .C_NWIN_WIDTH(16)) dut (
        .user_clk(user_clk), .user_resetn(user_resetn),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_window(cfg_window),
        .cfg_num_win(cfg_num_win), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .l3fwd_max(l3fwd_max), .l3fwd_en(l3fwd_en), .l3fwd_mode(l3fwd_mode),
        .l3fwd_rst(l3fwd_rst), .l3fwd_read(l3fwd_read),
        .win_max_i(win_max_i), .win_min_i(win_min_i), .win_sum_i(win_sum_i),
        .win_pkts_i(win_pkts_i),
        .busy(busy), .done(done), .aborted(aborted), .win_cnt(win_cnt),
        .agg_max(agg_max), .agg_min(agg_min), .agg_sum(agg_sum),
        .agg_pkts(agg_pkts), .agg_ovf(agg_ovf)
    );

    always #5 user_clk = ~user_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model results of the last run, used by directed follow-up checks.
    logic [63:0] r_max, r_min, r_sum, r_pkts;
    int          r_cnt;

    // One measurement run: starts, drives window results every cycle, models
    // sampling, completion and abort, then checks the finished state.
    task automatic run_case(input logic [63:0] w, input int n, input int abort_k,
                            input bit use_tbl, input bit en, input bit mode);
        logic [63:0] weff, m_max, m_min, m_sum, m_pkts, v;
        bit          m_ovf, exp_read, fin, exp_abort;
        int          m_cnt, per, k, idx;
        weff   = (w < 64'd3) ? 64'd3 : w;
        per    = int'(weff) + 1;
        m_max  = 64'd0;  m_min = ONES;  m_sum = 64'd0;  m_pkts = 64'd0;
        m_ovf  = 1'b0;   m_cnt = 0;     idx = 0;
        fin    = 1'b0;   exp_abort = 1'b0;

        @(negedge user_clk);
        cfg_window = w; cfg_num_win = 16'(n); cfg_en = en; cfg_mode = mode; cfg_start = 1'b1;
        @(negedge user_clk);
        cfg_start = 1'b0;
        check_val("start_max", l3fwd_max, weff);
        check_val("start_en", {63'd0, l3fwd_en}, {63'd0, en});
        check_val("start_mode", {63'd0, l3fwd_mode}, {63'd0, mode});
        check_val("start_flags", {60'd0, busy, done, aborted, agg_ovf}, {60'd0, 4'b1000});
        check_val("start_wcnt", {48'd0, win_cnt}, 64'd0);
        check_val("start_aggmin", agg_min, ONES);
        // Mid-run config changes must be ignored.
        cfg_window = {$urandom, $urandom}; cfg_num_win = 16'($urandom); cfg_mode = ~mode; cfg_en = ~en;

        k = 0;
        while (!fin && k < 2000) begin
            exp_read = (k > 0) && (k % per == 0);
            check_val("read", {63'd0, l3fwd_read}, {63'd0, exp_read});
            check_val("run_rst_busy", {62'd0, l3fwd_rst, busy}, {62'd0, 2'b01});
            if (exp_read && use_tbl) begin
                win_max_i = t_max[idx]; win_min_i = t_min[idx];
                win_sum_i = t_sum[idx]; win_pkts_i = t_pkts[idx];
            end else begin
                win_pkts_i = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 1000));
                win_min_i  = (win_pkts_i == 64'd0) ? ONES : 64'($urandom);
                win_max_i  = 64'($urandom);
                win_sum_i  = 64'($urandom);
            end
            if (exp_read) begin
                idx++;
                if (win_max_i > m_max) m_max = win_max_i;
                if (win_pkts_i != 64'd0 && win_min_i < m_min) m_min = win_min_i;
                v = win_sum_i;
                if (m_sum > ONES - v) begin m_sum = ONES; m_ovf = 1'b1; end else m_sum = m_sum + v;
                v = win_pkts_i;
                if (m_pkts > ONES - v) begin m_pkts = ONES; m_ovf = 1'b1; end else m_pkts = m_pkts + v;
                if (m_cnt != 65535) m_cnt++;
            end
            cfg_start = ($urandom_range(0, 15) == 0);
            cfg_abort = (k == abort_k);
            exp_abort = cfg_abort;
            fin = cfg_abort || (exp_read && n != 0 && m_cnt == n);
            k++;
            if (!fin) @(negedge user_clk);
        end
        if (!fin) check_val("cycle_budget", {63'd0, fin}, 64'd1);

        @(negedge user_clk);
        cfg_abort = 1'b0; cfg_start = 1'b0;
        check_val("end_flags", {60'd0, busy, done, aborted, agg_ovf}, {60'd0, 1'b0, 1'b1, exp_abort, m_ovf});
        check_val("end_ctrl", {61'd0, l3fwd_rst, l3fwd_en, l3fwd_read}, {61'd0, 3'b100});
        check_val("end_mode", {63'd0, l3fwd_mode}, {63'd0, mode});
        check_val("end_max", l3fwd_max, weff);
        check_val("end_wcnt", {48'd0, win_cnt}, 64'(m_cnt));
        check_val("agg_max", agg_max, m_max);
        check_val("agg_min", agg_min, m_min);
        check_val("agg_sum", agg_sum, m_sum);
        check_val("agg_pkts", agg_pkts, m_pkts);
        r_max = m_max; r_min = m_min; r_sum = m_sum; r_pkts = m_pkts; r_cnt = m_cnt;

        // Abort while finished is ignored and results hold.
        cfg_abort = 1'b1;
        @(negedge user_clk);
        cfg_abort = 1'b0;
        check_val("idle_abort", {61'd0, busy, done, aborted}, {61'd0, 1'b0, 1'b1, exp_abort});
        check_val("idle_hold", agg_sum, m_sum);
    endtask

    initial begin
        int n, ak, per;
        logic [63:0] w;

        #12;
        check_val("rst_ctrl", {61'd0, l3fwd_rst, l3fwd_read, l3fwd_en}, {61'd0, 3'b100});
        check_val("rst_max", l3fwd_max, 64'd0);
        user_resetn = 1'b1;
        @(negedge user_clk);
        check_val("rst_flags", {59'd0, busy, done, aborted, agg_ovf, l3fwd_mode}, 64'd0);
        check_val("rst_wcnt", {48'd0, win_cnt}, 64'd0);
        check_val("rst_aggs", agg_max | agg_sum | agg_pkts, 64'd0);
        check_val("rst_aggmin", agg_min, ONES);

        // Basic three-window run with fixed counter results.
        t_max[0] = 64'd20;  t_max[1] = 64'd30;  t_max[2] = 64'd25;  t_max[3] = 64'd0;
        t_min[0] = 64'd5;   t_min[1] = 64'd4;   t_min[2] = 64'd6;   t_min[3] = ONES;
        t_sum[0] = 64'd100; t_sum[1] = 64'd200; t_sum[2] = 64'd150; t_sum[3] = 64'd0;
        t_pkts[0] = 64'd10; t_pkts[1] = 64'd20; t_pkts[2] = 64'd15; t_pkts[3] = 64'd0;
        run_case(64'd9, 3, -1, 1'b1, 1'b1, 1'b0);
        check_val("tp1_max", agg_max, 64'd30);
        check_val("tp1_min", agg_min, 64'd4);
        check_val("tp1_sum", agg_sum, 64'd450);
        check_val("tp1_pkts", agg_pkts, 64'd45);
        check_val("tp1_wcnt", {48'd0, win_cnt}, 64'd3);

        // Window length below the minimum is clamped.
        run_case(64'd1, 2, -1, 1'b0, 1'b0, 1'b1);
        run_case(64'd0, 1, -1, 1'b0, 1'b1, 1'b1);

        // An empty window between two populated ones leaves the minimum alone.
        t_min[0] = 64'd7; t_min[1] = ONES;  t_min[2] = 64'd9;
        t_pkts[0] = 64'd3; t_pkts[1] = 64'd0; t_pkts[2] = 64'd4;
        run_case(64'd5, 3, -1, 1'b1, 1'b1, 1'b0);
        check_val("empty_min", agg_min, 64'd7);

        // Two windows of 2^63 saturate the sum.
        t_sum[0] = 64'h8000_0000_0000_0000; t_sum[1] = 64'h8000_0000_0000_0000;
        run_case(64'd4, 2, -1, 1'b1, 1'b1, 1'b0);
        check_val("sat_sum", agg_sum, ONES);
        check_val("sat_ovf", {63'd0, agg_ovf}, 64'd1);

        // Unbounded run aborted mid-window after two samples.
        run_case(64'd9, 0, 25, 1'b0, 1'b1, 1'b0);
        check_val("abort_wcnt", {48'd0, win_cnt}, 64'd2);
        check_val("abort_flag", {63'd0, aborted}, 64'd1);

        // Abort coinciding with a sample cycle still takes that sample.
        run_case(64'd3, 0, 8, 1'b0, 1'b0, 1'b0);
        check_val("abort_on_sample", {48'd0, win_cnt}, 64'd2);

        for (int i = 0; i < 8; i++) begin
            w   = 64'($urandom_range(0, 12));
            n   = $urandom_range(0, 4);
            per = ((w < 64'd3) ? 3 : int'(w)) + 1;
            if (n == 0) ak = $urandom_range(0, 3 * per + 5);
            else ak = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n * per + 2) : -1;
            run_case(w, n, ak, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a window.
        @(negedge user_clk);
        cfg_window = 64'd3; cfg_num_win = 16'd0; cfg_en = 1'b1; cfg_start = 1'b1;
        @(negedge user_clk);
        cfg_start = 1'b0;
        win_max_i = 64'd77; win_min_i = 64'd3; win_sum_i = 64'd50; win_pkts_i = 64'd2;
        repeat (6) @(negedge user_clk);
        check_val("pre_rst_wcnt", {48'd0, win_cnt}, 64'd1);
        #2;
        user_resetn = 1'b0;
        #1;
        check_val("arst_ctrl", {60'd0, busy, l3fwd_rst, l3fwd_en, l3fwd_read}, {60'd0, 4'b0100});
        check_val("arst_aggs", agg_max | agg_sum | agg_pkts | {48'd0, win_cnt}, 64'd0);
        check_val("arst_min", agg_min, ONES);
        check_val("arst_max", l3fwd_max, 64'd0);
        @(negedge user_clk);
        user_resetn = 1'b1;
        @(negedge user_clk);
        check_val("post_rst_idle", {62'd0, busy, l3fwd_rst}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
